// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared AXI widths, burst/response enums and channel structs
package ravenoc_pkg;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_USER_WIDTH = 1;

    typedef enum logic [1:0] {FIXED, INCR, WRAP, AXI_MEM_RSVD} axi_burst_t;
    typedef enum logic [1:0] {OKAY, EXOKAY, SLVERR, DECERR} axi_resp_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]     awid;
        logic [AXI_ADDR_WIDTH-1:0]   awaddr;
        logic [7:0]                  awlen;
        logic [2:0]                  awsize;
        axi_burst_t                  awburst;
        logic                        awlock;
        logic [3:0]                  awcache;
        logic [2:0]                  awprot;
        logic [3:0]                  awqos;
        logic [AXI_USER_WIDTH-1:0]   awuser;
        logic                        awvalid;
        logic [AXI_DATA_WIDTH-1:0]   wdata;
        logic [AXI_DATA_WIDTH/8-1:0] wstrb;
        logic                        wlast;
        logic [AXI_USER_WIDTH-1:0]   wuser;
        logic                        wvalid;
        logic                        bready;
        logic [AXI_ID_WIDTH-1:0]     arid;
        logic [AXI_ADDR_WIDTH-1:0]   araddr;
        logic [7:0]                  arlen;
        logic [2:0]                  arsize;
        axi_burst_t                  arburst;
        logic                        arlock;
        logic [3:0]                  arcache;
        logic [2:0]                  arprot;
        logic [3:0]                  arqos;
        logic [AXI_USER_WIDTH-1:0]   aruser;
        logic                        arvalid;
        logic                        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                        awready;
        logic                        wready;
        logic [AXI_ID_WIDTH-1:0]     bid;
        axi_resp_t                   bresp;
        logic [AXI_USER_WIDTH-1:0]   buser;
        logic                        bvalid;
        logic                        arready;
        logic [AXI_ID_WIDTH-1:0]     rid;
        logic [AXI_DATA_WIDTH-1:0]   rdata;
        axi_resp_t                   rresp;
        logic                        rlast;
        logic [AXI_USER_WIDTH-1:0]   ruser;
        logic                        rvalid;
    } s_axi_miso_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
    import ravenoc_pkg::*;
(
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [2:0]                size,
    input  logic [7:0]                len,
    input  axi_burst_t                burst,
    output logic [AXI_ADDR_WIDTH-1:0] next_addr
);
    localparam logic [AXI_ADDR_WIDTH-1:0] ONE = 1;
    logic [AXI_ADDR_WIDTH-1:0] incr, mask;
    assign incr = ONE << size;
    assign mask = (((AXI_ADDR_WIDTH)'(len) + ONE) << size) - ONE;
    assign next_addr = burst == FIXED ? addr :
                       burst == WRAP  ? (addr & ~mask) | ((addr + incr) & mask) :
                                        addr + incr;
endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 memory responder, independent read/write engines; AXI_MEM_SLVERR_EN adds SLVERR checks
module axi_mem_slave
    import ravenoc_pkg::*;
#(
    parameter int                        MEM_KB    = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic        clk,
    input  logic        arst,
    input  s_axi_mosi_t axi_mosi,
    output s_axi_miso_t axi_miso
);
    localparam int AW        = AXI_ADDR_WIDTH;
    localparam int MEM_BYTES = MEM_KB * 1024;
    localparam int LSB       = $clog2(AXI_DATA_WIDTH / 8);
    localparam int IW        = $clog2(MEM_BYTES) - LSB;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_st_t;
    typedef enum logic {R_IDLE, R_DATA} rd_st_t;

    wr_st_t wr_st, wr_nxt;
    rd_st_t rd_st, rd_nxt;
    logic [AW-1:0] aw_off, ar_off, wr_addr, wr_addr_nxt, rd_addr, rd_addr_nxt;
    logic [AXI_ID_WIDTH-1:0] wr_id, rd_id;
    logic [7:0] wr_len, wr_beat, rd_len, rd_beat;
    logic [2:0] wr_size, rd_size;
    axi_burst_t wr_burst, rd_burst;
    axi_resp_t bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic awready_q, wready_q, bvalid_q, arready_q, rvalid_q, rlast_q;
    logic wr_err, wr_bad, rd_err, aw_err, ar_err, wlast_err;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_beat, r_last_beat;
    logic unused_ok;
    logic [AXI_DATA_WIDTH-1:0] mem [2**IW];

    function automatic logic [IW-1:0] widx(input logic [AW-1:0] a);
        return a[LSB +: IW];
    endfunction

    assign aw_off      = axi_mosi.awaddr - BASE_ADDR;
    assign ar_off      = axi_mosi.araddr - BASE_ADDR;
    assign aw_hs       = axi_mosi.awvalid & awready_q;
    assign w_hs        = axi_mosi.wvalid & wready_q;
    assign b_hs        = axi_mosi.bready & bvalid_q;
    assign ar_hs       = axi_mosi.arvalid & arready_q;
    assign r_hs        = axi_mosi.rready & rvalid_q;
    assign w_last_beat = wr_beat == wr_len;
    assign r_last_beat = rd_beat == rd_len;
    assign unused_ok   = ^axi_mosi;

`ifdef AXI_MEM_SLVERR_EN
    assign aw_err = aw_off >= AW'(MEM_BYTES) || axi_mosi.awsize > 3'(LSB) ||
                    (axi_mosi.awburst == WRAP && !(axi_mosi.awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    assign ar_err = ar_off >= AW'(MEM_BYTES) || axi_mosi.arsize > 3'(LSB) ||
                    (axi_mosi.arburst == WRAP && !(axi_mosi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    assign wlast_err = axi_mosi.wlast != w_last_beat;
`else
    assign aw_err    = 1'b0;
    assign ar_err    = 1'b0;
    assign wlast_err = 1'b0;
`endif

    axi_burst_addr_gen u_wr_gen (.addr(wr_addr), .size(wr_size), .len(wr_len), .burst(wr_burst), .next_addr(wr_addr_nxt));
    axi_burst_addr_gen u_rd_gen (.addr(rd_addr), .size(rd_size), .len(rd_len), .burst(rd_burst), .next_addr(rd_addr_nxt));

    // Write engine next state: address, data beats, then response
    always_comb begin
        wr_nxt = wr_st == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                 wr_st == W_DATA ? (w_hs && w_last_beat ? W_RESP : W_DATA) :
                                   (b_hs ? W_IDLE : W_RESP);
    end

    // Write engine state, latched burst parameters and registered AW/W/B outputs
    always_ff @(posedge clk) begin
        if (!arst) begin
            wr_st     <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            wr_id     <= '0;
            wr_addr   <= '0;
            wr_len    <= '0;
            wr_beat   <= '0;
            wr_size   <= '0;
            wr_burst  <= FIXED;
            wr_err    <= 1'b0;
            wr_bad    <= 1'b0;
        end else begin
            wr_st     <= wr_nxt;
            awready_q <= wr_nxt == W_IDLE;
            wready_q  <= wr_nxt == W_DATA;
            bvalid_q  <= wr_nxt == W_RESP;
            if (aw_hs) begin
                wr_id    <= axi_mosi.awid;
                wr_addr  <= aw_off;
                wr_len   <= axi_mosi.awlen;
                wr_size  <= axi_mosi.awsize;
                wr_burst <= axi_mosi.awburst;
                wr_beat  <= '0;
                wr_err   <= aw_err;
                wr_bad   <= 1'b0;
            end
            if (w_hs) begin
                wr_addr <= wr_addr_nxt;
                wr_beat <= wr_beat + 8'd1;
                wr_bad  <= wr_bad | wlast_err;
            end
            if (w_hs && w_last_beat)
                bresp_q <= (wr_err || wr_bad || wlast_err) ? SLVERR : OKAY;
        end
    end

    // Byte-lane memory writes; memory contents are not reset
    always_ff @(posedge clk) begin
        if (arst && w_hs && !wr_err)
            for (int i = 0; i < AXI_DATA_WIDTH / 8; i++)
                if (axi_mosi.wstrb[i])
                    mem[widx(wr_addr)][8*i +: 8] <= axi_mosi.wdata[8*i +: 8];
    end

    // Read engine next state: leave R_DATA once the last beat is accepted
    always_comb begin
        rd_nxt = rd_st == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) :
                                   (r_hs && r_last_beat ? R_IDLE : R_DATA);
    end

    // Read engine state and registered R outputs; next beat is fetched on the accepting edge
    always_ff @(posedge clk) begin
        if (!arst) begin
            rd_st     <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            rd_id     <= '0;
            rd_addr   <= '0;
            rd_len    <= '0;
            rd_beat   <= '0;
            rd_size   <= '0;
            rd_burst  <= FIXED;
            rd_err    <= 1'b0;
        end else begin
            rd_st     <= rd_nxt;
            arready_q <= rd_nxt == R_IDLE;
            rvalid_q  <= rd_nxt == R_DATA;
            if (ar_hs) begin
                rd_id    <= axi_mosi.arid;
                rd_addr  <= ar_off;
                rd_len   <= axi_mosi.arlen;
                rd_size  <= axi_mosi.arsize;
                rd_burst <= axi_mosi.arburst;
                rd_beat  <= '0;
                rd_err   <= ar_err;
                rdata_q  <= ar_err ? '0 : mem[widx(ar_off)];
                rresp_q  <= ar_err ? SLVERR : OKAY;
                rlast_q  <= axi_mosi.arlen == 8'd0;
            end
            if (r_hs && !r_last_beat) begin
                rd_addr <= rd_addr_nxt;
                rd_beat <= rd_beat + 8'd1;
                rdata_q <= rd_err ? '0 : mem[widx(rd_addr_nxt)];
                rlast_q <= rd_beat + 8'd1 == rd_len;
            end
        end
    end

    // Drive the response bundle straight from registers
    always_comb begin
        axi_miso         = '0;
        axi_miso.awready = awready_q;
        axi_miso.wready  = wready_q;
        axi_miso.bvalid  = bvalid_q;
        axi_miso.bid     = wr_id;
        axi_miso.bresp   = bresp_q;
        axi_miso.arready = arready_q;
        axi_miso.rvalid  = rvalid_q;
        axi_miso.rid     = rd_id;
        axi_miso.rdata   = rdata_q;
        axi_miso.rresp   = rresp_q;
        axi_miso.rlast   = rlast_q;
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed self-checking bench for axi_mem_slave
module tb_axi_mem_slave;
    import ravenoc_pkg::*;

    logic clk = 1'b0;
    logic arst = 1'b0;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] got_d [16];
    logic        got_l [16];
    logic [1:0]  got_r [16];
    logic [31:0] wrap_exp [4] = '{32'd3, 32'd4, 32'd1, 32'd2};

    axi_mem_slave #(.MEM_KB(8), .BASE_ADDR('0)) dut (
        .clk(clk), .arst(arst), .axi_mosi(mosi), .axi_miso(miso)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [31:0] a, input logic [7:0] len, input axi_burst_t b, input logic [3:0] id);
        mosi.awaddr = a; mosi.awlen = len; mosi.awsize = 3'd2; mosi.awburst = b; mosi.awid = id;
        mosi.awvalid = 1'b1;
        for (int t = 0; t < 20 && !miso.awready; t++) tick();
        check("awready_to", miso.awready, 1);
        tick();
        mosi.awvalid = 1'b0;
    endtask

    task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic last);
        mosi.wdata = d; mosi.wstrb = s; mosi.wlast = last; mosi.wvalid = 1'b1;
        for (int t = 0; t < 20 && !miso.wready; t++) tick();
        check("wready_to", miso.wready, 1);
        tick();
        mosi.wvalid = 1'b0;
    endtask

    task automatic bwait(input logic [3:0] id);
        mosi.bready = 1'b1;
        for (int t = 0; t < 20 && !miso.bvalid; t++) tick();
        check("bvalid", miso.bvalid, 1);
        check("bid", miso.bid, id);
        check("bresp", miso.bresp, OKAY);
        tick();
        mosi.bready = 1'b0;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        aw(a, 8'd0, INCR, 4'd1);
        wbeat(d, s, 1'b1);
        bwait(4'd1);
    endtask

    task automatic ar(input logic [31:0] a, input logic [7:0] len, input axi_burst_t b, input logic [3:0] id);
        mosi.araddr = a; mosi.arlen = len; mosi.arsize = 3'd2; mosi.arburst = b; mosi.arid = id;
        mosi.arvalid = 1'b1;
        for (int t = 0; t < 20 && !miso.arready; t++) tick();
        check("arready_to", miso.arready, 1);
        tick();
        mosi.arvalid = 1'b0;
        check("r_latency", miso.rvalid, 1);
    endtask

    task automatic rcollect(input int n, input logic [3:0] id);
        mosi.rready = 1'b1;
        for (int k = 0; k < n; k++) begin
            for (int t = 0; t < 20 && !miso.rvalid; t++) tick();
            check("rvalid", miso.rvalid, 1);
            check("rid", miso.rid, id);
            got_d[k] = miso.rdata;
            got_l[k] = miso.rlast;
            got_r[k] = miso.rresp;
            tick();
        end
        mosi.rready = 1'b0;
    endtask

    initial begin
        mosi = '0;
        repeat (3) tick();
        check("rst_awready", miso.awready, 0);
        check("rst_arready", miso.arready, 0);
        check("rst_wready", miso.wready, 0);
        check("rst_bvalid", miso.bvalid, 0);
        check("rst_rvalid", miso.rvalid, 0);
        check("rst_rdata", miso.rdata, 0);
        arst = 1'b1;
        tick();
        check("awready_up", miso.awready, 1);
        check("arready_up", miso.arready, 1);

        // single beat write and readback
        aw(32'h10, 8'd0, INCR, 4'd3);
        check("awready_drop", miso.awready, 0);
        wbeat(32'hDEADBEEF, 4'hF, 1'b1);
        bwait(4'd3);
        ar(32'h10, 8'd0, INCR, 4'd6);
        rcollect(1, 4'd6);
        check("t1_rdata", got_d[0], 32'hDEADBEEF);
        check("t1_rlast", got_l[0], 1);
        check("t1_rresp", got_r[0], OKAY);

        // byte strobes
        wr1(32'h10, 32'hFFFFFFFF, 4'hF);
        wr1(32'h10, 32'h0000AAAA, 4'b0011);
        ar(32'h10, 8'd0, INCR, 4'd2);
        rcollect(1, 4'd2);
        check("t2_strb", got_d[0], 32'hFFFFAAAA);

        // INCR burst write, WRAP burst read
        aw(32'h20, 8'd3, INCR, 4'd4);
        for (int k = 0; k < 4; k++) wbeat(32'(k + 1), 4'hF, k == 3);
        bwait(4'd4);
        ar(32'h28, 8'd3, WRAP, 4'd7);
        rcollect(4, 4'd7);
        for (int k = 0; k < 4; k++) begin
            check("t3_wrap_data", got_d[k], wrap_exp[k]);
            check("t3_wrap_last", got_l[k], k == 3);
        end

        // FIXED burst keeps hitting one word; last beat wins
        aw(32'h50, 8'd1, FIXED, 4'd1);
        wbeat(32'h11111111, 4'hF, 1'b0);
        wbeat(32'h22222222, 4'hF, 1'b1);
        bwait(4'd1);
        ar(32'h50, 8'd0, INCR, 4'd1);
        rcollect(1, 4'd1);
        check("fixed_data", got_d[0], 32'h22222222);

        // backpressure mid-burst
        ar(32'h20, 8'd3, INCR, 4'd8);
        rcollect(1, 4'd8);
        check("t4_beat0", got_d[0], 32'd1);
        repeat (5) tick();
        check("t4_hold_valid", miso.rvalid, 1);
        check("t4_hold_data", miso.rdata, 32'd2);
        check("t4_hold_last", miso.rlast, 0);
        rcollect(3, 4'd8);
        check("t4_beat1", got_d[0], 32'd2);
        check("t4_beat2", got_d[1], 32'd3);
        check("t4_beat3", got_d[2], 32'd4);
        check("t4_last", got_l[2], 1);
        check("t4_done", miso.rvalid, 0);

        // AW and AR in the same cycle
        mosi.awaddr = 32'h40; mosi.awlen = 8'd0; mosi.awsize = 3'd2; mosi.awburst = INCR; mosi.awid = 4'd9;
        mosi.araddr = 32'h10; mosi.arlen = 8'd0; mosi.arsize = 3'd2; mosi.arburst = INCR; mosi.arid = 4'd5;
        mosi.awvalid = 1'b1; mosi.arvalid = 1'b1;
        check("t5_awready", miso.awready, 1);
        check("t5_arready", miso.arready, 1);
        tick();
        mosi.awvalid = 1'b0; mosi.arvalid = 1'b0;
        check("t5_rvalid", miso.rvalid, 1);
        check("t5_wready", miso.wready, 1);
        wbeat(32'h12345678, 4'hF, 1'b1);
        bwait(4'd9);
        rcollect(1, 4'd5);
        check("t5_rdata", got_d[0], 32'hFFFFAAAA);
        ar(32'h40, 8'd0, INCR, 4'd0);
        rcollect(1, 4'd0);
        check("t5_wdata", got_d[0], 32'h12345678);

        // address at MEM_BYTES
        wr1(32'h0, 32'hCAFEF00D, 4'hF);
        ar(32'h2000, 8'd0, INCR, 4'd3);
        rcollect(1, 4'd3);
`ifdef AXI_MEM_SLVERR_EN
        check("t6_err_data", got_d[0], 32'h0);
        check("t6_err_resp", got_r[0], SLVERR);
`else
        check("t6_alias_data", got_d[0], 32'hCAFEF00D);
        check("t6_alias_resp", got_r[0], OKAY);
`endif

        // reset in the middle of a write burst
        aw(32'h60, 8'd3, INCR, 4'd2);
        wbeat(32'hA5A5A5A5, 4'hF, 1'b0);
        arst = 1'b0;
        tick();
        check("t6_rst_bvalid", miso.bvalid, 0);
        check("t6_rst_awready", miso.awready, 0);
        check("t6_rst_wready", miso.wready, 0);
        arst = 1'b1;
        tick();
        check("t6_rel_awready", miso.awready, 1);
        repeat (3) tick();
        check("t6_rel_bvalid", miso.bvalid, 0);
        ar(32'h60, 8'd0, INCR, 4'd1);
        rcollect(1, 4'd1);
        check("t6_kept_beat", got_d[0], 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
